// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store decode definitions: LDST size codes (funct3 encoding),
// controller state type, and the request decode helpers used by lsu_ctrl.
package lsu_ctrl_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    ERR
  } lsu_state_e;

  // Misaligned access, undefined size code, or a store using an unsigned size.
  function automatic logic ldst_illegal(input logic we, input logic [2:0] size,
                                        input logic [1:0] off);
    logic ill;
    case (size)
      LDST_B:  ill = 1'b0;
      LDST_BU: ill = we;
      LDST_H:  ill = off[0];
      LDST_HU: ill = we | off[0];
      LDST_W:  ill = (off != 2'b00);
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [3:0] ldst_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << off;
      LDST_H, LDST_HU: be = off[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data into every lane it could land in.
  function automatic logic [31:0] ldst_wd(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] data;
    case (size)
      LDST_B, LDST_BU: data = {4{wd[7:0]}};
      LDST_H, LDST_HU: data = {2{wd[15:0]}};
      default:         data = wd;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/lsu_rd_align.sv
// Load data alignment: selects the addressed byte/half/word from the raw
// memory word and sign- or zero-extends it to 32 bits.
//  size_i  LDST size code
//  off_i   byte offset within the word (addr[1:0])
//  word_i  raw memory read word
//  data_o  aligned, extended load result
module lsu_rd_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'h0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the core datapath and a registered-read data
// memory. Issues one memory access per core request, stalls the core until it
// completes, returns aligned/extended load data, and flags illegal requests
// with a one-cycle error pulse without touching memory.
//  clk_i, rst_ni          clock, synchronous active-low reset
//  core_req_i/we/size/addr/wd   core request (held stable while stalled)
//  core_rd_o, core_stall_o, core_err_o  core response
//  mem_req_o/we/be/addr/wd       memory request
//  mem_rd_i, mem_ready_i         memory read data (1-cycle latency), accept
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        req_int, stall_int, err_int;
  logic        illegal;
  logic [31:0] rd_aligned;

  assign illegal = ldst_illegal(core_we_i, core_size_i, core_addr_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      size_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    off_d     = off_q;
    we_d      = we_q;
    req_int   = 1'b0;
    stall_int = 1'b0;
    err_int   = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          stall_int = 1'b1;
          if (illegal) begin
            state_d = ERR;
          end else begin
            req_int = 1'b1;
            if (mem_ready_i) begin
              size_d  = core_size_i;
              off_d   = core_addr_i[1:0];
              we_d    = core_we_i;
              state_d = RESP;
            end
          end
        end
      end
      // The core still presents the same instruction here; it is not reissued.
      RESP:    state_d = IDLE;
      ERR: begin
        err_int = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_rd_align u_rd_align (
    .size_i (size_q),
    .off_i  (off_q),
    .word_i (mem_rd_i),
    .data_o (rd_aligned)
  );

  // Reset overrides the handshake outputs combinationally so nothing leaks
  // out while rst_ni is low, even before the state register has cleared.
  assign mem_req_o    = req_int & rst_ni;
  assign mem_we_o     = core_we_i & mem_req_o;
  assign core_stall_o = stall_int & rst_ni;
  assign core_err_o   = err_int & rst_ni;
  assign mem_addr_o   = core_addr_i;
  assign mem_be_o     = ldst_be(core_size_i, core_addr_i[1:0]);
  assign mem_wd_o     = ldst_wd(core_size_i, core_wd_i);
  assign core_rd_o    = (rst_ni && (state_q == RESP) && !we_q) ? rd_aligned : '0;

endmodule
